pipe_stage_buf: RTL and testbench

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

---
 rtl/pipe_stage_buf_pkg.sv | 22 ++
 rtl/pipe_stage_buf_if.sv | 12 +
 rtl/pipe_stage_cnt.sv | 15 +
 rtl/pipe_stage_buf.sv | 67 ++++++
 tb/tb_pipe_stage_buf.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_buf_pkg.sv
// pipe_stage_buf_pkg: shared pipeline widths and control-bundle bit positions
package pipe_stage_buf_pkg;
   localparam int CTRL_W = 10;
   localparam int DATA_W = 149;
   localparam int CTRL_BRANCH  = 0;
   localparam int CTRL_JUMP    = 1;
   localparam int CTRL_MEM_RD  = 2;
   localparam int CTRL_MEM_WR  = 3;
   localparam int CTRL_ALU_LSB = 4;
   localparam int CTRL_ALU_W   = 4;
   localparam int CTRL_REG_WR  = 8;
   localparam int CTRL_MEM2REG = 9;
   typedef struct packed {
      logic       mem2reg;
      logic       reg_wr;
      logic [3:0] alu_op;
      logic       mem_wr;
      logic       mem_rd;
      logic       jump;
      logic       branch;
   } pipe_ctrl_t;
endpackage

// File: rtl/pipe_stage_buf_if.sv
// pipe_stage_buf_if: valid/ready handshake carrying a control and a data bundle
interface pipe_stage_buf_if #(
   parameter int CTRL_W = pipe_stage_buf_pkg::CTRL_W,
   parameter int DATA_W = pipe_stage_buf_pkg::DATA_W
);
   logic              valid;
   logic              ready;
   logic [CTRL_W-1:0] ctrl;
   logic [DATA_W-1:0] data;
   modport master(output valid, ctrl, data, input ready);
   modport slave(input valid, ctrl, data, output ready);
endinterface

// File: rtl/pipe_stage_cnt.sv
// pipe_stage_cnt: saturating up-counter with synchronous clear
module pipe_stage_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   always_ff @(posedge clk or negedge reset)
      if (!reset) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (inc && cnt != '1) cnt <= cnt + W'(1);
endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: two-entry (main + skid) pipeline register with flush and stall counter
module pipe_stage_buf #(
   parameter int CTRL_W = pipe_stage_buf_pkg::CTRL_W,
   parameter int DATA_W = pipe_stage_buf_pkg::DATA_W,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   pipe_stage_buf_if.slave  in_if,
   pipe_stage_buf_if.master out_if,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] stall_cnt
);
   logic              main_v, skid_v, rdy;
   logic [CTRL_W-1:0] main_c, skid_c;
   logic [DATA_W-1:0] main_d, skid_d;
   logic              acc, emit, load_main, main_v_n, skid_v_n;
   always_comb begin
      acc       = in_if.valid & rdy;
      emit      = main_v & out_if.ready;
      load_main = emit | ~main_v;
      main_v_n  = load_main ? (skid_v | acc) : main_v;
      skid_v_n  = skid_v ? ~emit : (acc & ~load_main);
   end
   // invalid entries always carry an all-zero control bundle so bubbles act as NOPs
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         main_v <= 1'b0;
         skid_v <= 1'b0;
         rdy    <= 1'b0;
         main_c <= '0;
         skid_c <= '0;
         main_d <= '0;
         skid_d <= '0;
      end else if (flush) begin
         main_v <= 1'b0;
         skid_v <= 1'b0;
         rdy    <= 1'b1;
         main_c <= '0;
         skid_c <= '0;
      end else begin
         main_v <= main_v_n;
         skid_v <= skid_v_n;
         rdy    <= ~skid_v_n;
         if (load_main) begin
            main_c <= skid_v ? skid_c : (acc ? in_if.ctrl : '0);
            main_d <= skid_v ? skid_d : in_if.data;
         end
         if (!skid_v_n) skid_c <= '0;
         else if (!skid_v) begin
            skid_c <= in_if.ctrl;
            skid_d <= in_if.data;
         end
      end
   assign in_if.ready  = rdy;
   assign out_if.valid = main_v;
   assign out_if.ctrl  = main_c;
   assign out_if.data  = main_d;
   pipe_stage_cnt #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_cnt),
      .inc   (main_v & ~out_if.ready),
      .cnt   (stall_cnt)
   );
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: randomized scoreboard bench; reference is a 2-deep in-order queue
module tb_pipe_stage_buf;
   localparam int CW = pipe_stage_buf_pkg::CTRL_W;
   localparam int DW = pipe_stage_buf_pkg::DATA_W;
   localparam int NW = 4;
   typedef struct packed {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } ent_t;
   logic clk = 0, reset = 1, flush = 0, clr_cnt = 0;
   logic [NW-1:0] stall_cnt;
   pipe_stage_buf_if #(.CTRL_W(CW), .DATA_W(DW)) up ();
   pipe_stage_buf_if #(.CTRL_W(CW), .DATA_W(DW)) dn ();
   pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_if     (up),
      .out_if    (dn),
      .clr_cnt   (clr_cnt),
      .stall_cnt (stall_cnt)
   );
   always #5 clk = ~clk;
   ent_t q[$];
   bit   model_rdy = 0, last_acc = 0;
   int   exp_stall = 0, vectors = 0, miscompares = 0;

   function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic [DW-1:0] rnd_data();
      logic [159:0] r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return r[DW-1:0];
   endfunction

   // monitor: at mid-cycle, compare DUT against the model and retire emitted entries
   always @(negedge clk) begin
      chk("out_valid", dn.valid, q.size() > 0);
      chk("in_ready", up.ready, model_rdy);
      chk("stall_cnt", stall_cnt, exp_stall);
      if (!dn.valid) chk("bubble_ctrl", dn.ctrl, 0);
      else if (q.size() > 0) begin
         chk("out_ctrl", dn.ctrl, q[0].c);
         chk("out_data", dn.data, q[0].d);
      end
      if (reset) begin
         if (clr_cnt) exp_stall = 0;
         else if (q.size() > 0 && !dn.ready && exp_stall < 2**NW - 1) exp_stall++;
         if (!flush && q.size() > 0 && dn.ready) void'(q.pop_front());
      end
   end

   // advance one edge, updating the model's acceptance from the inputs driven this cycle
   task automatic tick();
      @(posedge clk);
      last_acc = 0;
      if (!reset) model_rdy = 0;
      else if (flush) begin
         q.delete();
         model_rdy = 1;
      end else begin
         if (up.valid && model_rdy) begin
            q.push_back(ent_t'{c: up.ctrl, d: up.data});
            last_acc = 1;
         end
         model_rdy = q.size() < 2;
      end
      #1;
   endtask

   task automatic put(bit v, logic [CW-1:0] c);
      up.valid = v;
      up.ctrl  = c;
      up.data  = rnd_data();
   endtask

   task automatic push_until_taken(logic [CW-1:0] c);
      put(1, c);
      last_acc = 0;
      for (int i = 0; i < 12 && !last_acc; i++) tick();
      up.valid = 0;
   endtask

   initial begin
      put(0, '0);
      dn.ready = 0;
      #1 reset = 0;
      repeat (3) tick();
      reset = 1;
      tick();
      // streaming 1..8 at full rate
      dn.ready = 1;
      for (int i = 1; i <= 8; i++) begin
         put(1, CW'(i));
         tick();
      end
      put(0, '0);
      repeat (3) tick();
      // backpressure: A to main, B to skid, C held upstream
      push_until_taken(CW'(10'h0A));
      dn.ready = 0;
      push_until_taken(CW'(10'h0B));
      put(1, CW'(10'h0C));
      repeat (4) tick();
      dn.ready = 1;
      push_until_taken(CW'(10'h0C));
      repeat (4) tick();
      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         put($urandom_range(3) != 0, CW'($urandom()));
         dn.ready = $urandom_range(2) != 0;
         flush    = $urandom_range(39) == 0;
         clr_cnt  = $urandom_range(24) == 0;
         tick();
      end
      put(0, '0);
      flush = 0;
      clr_cnt = 0;
      dn.ready = 1;
      repeat (3) tick();
      // flush with both entries full and a live input
      dn.ready = 0;
      push_until_taken(CW'(10'h111));
      push_until_taken(CW'(10'h122));
      put(1, CW'(10'h3FF));
      flush = 1;
      tick();
      flush = 0;
      put(0, '0);
      chk("flush_valid", dn.valid, 0);
      chk("flush_ctrl", dn.ctrl, 0);
      chk("flush_ready", up.ready, 1);
      dn.ready = 1;
      repeat (2) tick();
      // stall counter saturation and clear
      clr_cnt = 1;
      tick();
      clr_cnt = 0;
      dn.ready = 0;
      push_until_taken(CW'(10'h055));
      repeat (20) tick();
      chk("stall_sat", stall_cnt, 15);
      clr_cnt = 1;
      tick();
      clr_cnt = 0;
      chk("stall_clr", stall_cnt, 0);
      dn.ready = 1;
      repeat (2) tick();
      // asynchronous reset with skid full
      dn.ready = 0;
      push_until_taken(CW'(10'h066));
      push_until_taken(CW'(10'h077));
      put(1, CW'(10'h088));
      #2 reset = 0;
      q.delete();
      model_rdy = 0;
      exp_stall = 0;
      #1;
      chk("rst_valid", dn.valid, 0);
      chk("rst_ctrl", dn.ctrl, 0);
      chk("rst_data", dn.data, 0);
      chk("rst_ready", up.ready, 0);
      chk("rst_stall", stall_cnt, 0);
      repeat (2) tick();
      reset = 1;
      tick();
      chk("rel_ready", up.ready, 1);
      chk("rel_valid", dn.valid, 0);
      dn.ready = 1;
      tick();
      put(0, '0);
      repeat (5) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
